// File: rtl/program_sequencer.sv
// program_sequencer: fetch/decode/issue sequencer handling HALT/JMP/JNZ locally, other ops via ICU handshake
module program_sequencer #(
  parameter int N          = 2,
  parameter int FETCH_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         step_mode,
  input  logic         step,
  output logic [N-1:0] rom_addr,
  input  logic [7:0]   rom_data,
  output logic         exec_valid,
  output logic [3:0]   exec_op,
  output logic [3:0]   exec_arg,
  input  logic         exec_ready,
  input  logic         flag,
  output logic [N-1:0] pc,
  output logic         busy,
  output logic         halted
);
  localparam int CW = FETCH_WAIT > 1 ? $clog2(FETCH_WAIT) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, STEP_WAIT, HALTED} state_t;
  state_t       state;
  state_t       nxt;
  logic [7:0]   ir;
  logic [CW-1:0] cnt;
  logic [N-1:0] target;
  assign rom_addr = pc;
  assign target   = ir[N-1:0];
  assign nxt      = step_mode ? STEP_WAIT : FETCH;
  assign busy     = state inside {FETCH, DECODE, ISSUE, STEP_WAIT};
  assign halted   = state == HALTED;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      cnt        <= '0;
      exec_valid <= 1'b0;
      exec_op    <= '0;
      exec_arg   <= '0;
    end else
      case (state)
        IDLE, HALTED:
          if (start) begin
            pc    <= '0;
            cnt   <= '0;
            state <= FETCH;
          end
        FETCH:
          if (cnt == CW'(FETCH_WAIT - 1)) begin
            ir    <= rom_data;
            cnt   <= '0;
            state <= DECODE;
          end else
            cnt <= cnt + 1'b1;
        DECODE:
          case (ir[7:4])
            4'hF: state <= HALTED;
            4'hE: begin
              pc    <= target;
              state <= nxt;
            end
            4'hD: begin
              pc    <= flag ? target : pc + 1'b1;
              state <= nxt;
            end
            default: begin
              exec_valid <= 1'b1;
              exec_op    <= ir[7:4];
              exec_arg   <= ir[3:0];
              state      <= ISSUE;
            end
          endcase
        ISSUE:
          if (exec_ready) begin
            exec_valid <= 1'b0;
            pc         <= pc + 1'b1;
            state      <= nxt;
          end
        STEP_WAIT: if (step || !step_mode) state <= FETCH;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed-vector bench for program_sequencer
module tb_program_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, step_mode, step, exec_ready, flag;
  logic [1:0] rom_addr, pc;
  logic [7:0] rom_data;
  logic       exec_valid, busy, halted;
  logic [3:0] exec_op, exec_arg;
  logic [7:0] rom [4];
  logic       start3;
  logic [1:0] rom_addr3, pc3;
  logic       exec_valid3, busy3, halted3;
  logic [3:0] exec_op3, exec_arg3;
  int checks = 0;
  int errors = 0;
  logic [7:0] acc [$];
  logic [1:0] seq [$];
  logic [1:0] last_pc;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  program_sequencer #(.N(2), .FETCH_WAIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .rom_addr(rom_addr), .rom_data(rom_data), .exec_valid(exec_valid),
    .exec_op(exec_op), .exec_arg(exec_arg), .exec_ready(exec_ready), .flag(flag),
    .pc(pc), .busy(busy), .halted(halted));

  program_sequencer #(.N(2), .FETCH_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .step_mode(1'b0), .step(1'b0),
    .rom_addr(rom_addr3), .rom_data(8'h10), .exec_valid(exec_valid3),
    .exec_op(exec_op3), .exec_arg(exec_arg3), .exec_ready(1'b1), .flag(1'b0),
    .pc(pc3), .busy(busy3), .halted(halted3));

  always @(posedge clk)
    if (rst && exec_valid && exec_ready) acc.push_back({exec_op, exec_arg});

  task automatic tick();
    @(posedge clk);
    #1;
    if (pc != last_pc) begin
      seq.push_back(pc);
      last_pc = pc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    acc.delete();
    seq.delete();
    seq.push_back(2'd0);
    last_pc = 2'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; step_mode = 0; step = 0; exec_ready = 0; flag = 0; start3 = 0;
    rom = '{8'h13, 8'h25, 8'h30, 8'hF0};
    last_pc = 2'd0;
    tick();
    do_reset();
    tick();
    checks++;
    if ({exec_valid, busy, halted, pc, rom_addr, exec_op, exec_arg} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {exec_valid, busy, halted, pc, rom_addr, exec_op, exec_arg});
    end
  endtask

  task automatic test_run();
    int n = 0;
    exec_ready = 1'b1;
    acc.delete();
    pulse_start();
    while (!halted && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 11) begin errors++; $display("FAIL run_latency got %0d exp 11", n); end
    checks++;
    if (pc !== 2'd3 || busy !== 1'b0) begin errors++; $display("FAIL run_halt_pc got pc=%0d busy=%b exp pc=3 busy=0", pc, busy); end
    checks++;
    if (acc.size() !== 3) begin errors++; $display("FAIL run_icu_count got %0d exp 3", acc.size()); end
    else begin
      checks++;
      if (acc[0] !== 8'h13 || acc[1] !== 8'h25 || acc[2] !== 8'h30) begin
        errors++; $display("FAIL run_icu_ops got %h %h %h exp 13 25 30", acc[0], acc[1], acc[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    exec_ready = 1'b0;
    pulse_start();
    while (!exec_valid && n < 20) begin tick(); n++; end
    checks++;
    if (exec_valid !== 1'b1) begin errors++; $display("FAIL bp_issue_timeout got 0 exp 1"); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({exec_valid, exec_op, exec_arg, pc} !== {1'b1, 8'h13, 2'd0}) begin
        errors++; $display("FAIL bp_hold cyc %0d got %h exp %h", i, {exec_valid, exec_op, exec_arg, pc}, {1'b1, 8'h13, 2'd0});
      end
    end
    exec_ready = 1'b1;
    tick();
    checks++;
    if (pc !== 2'd1 || exec_valid !== 1'b0) begin errors++; $display("FAIL bp_release got pc=%0d v=%b exp pc=1 v=0", pc, exec_valid); end
    n = 0;
    while (!halted && n < 40) begin tick(); n++; end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL bp_halt_timeout got 0 exp 1"); end
  endtask

  task automatic test_reset_mid_issue();
    int n = 0;
    exec_ready = 1'b1;
    acc.delete();
    pulse_start();
    while (!(exec_valid && pc == 2'd1) && n < 30) begin tick(); n++; end
    exec_ready = 1'b0;
    checks++;
    if (exec_valid !== 1'b1 || pc !== 2'd1) begin errors++; $display("FAIL rmi_setup got v=%b pc=%0d exp v=1 pc=1", exec_valid, pc); end
    rst = 1'b0;
    #1;
    checks++;
    if ({exec_valid, pc, busy, halted} !== 5'd0) begin
      errors++; $display("FAIL rmi_async got %b exp 00000", {exec_valid, pc, busy, halted});
    end
    checks++;
    if (acc.size() !== 1) begin errors++; $display("FAIL rmi_not_accepted got %0d exp 1", acc.size()); end
    do_reset();
  endtask

  task automatic test_flow(input logic f, input logic [1:0] e0, e1, e2, e3, e4);
    do_reset();
    rom = '{8'hD2, 8'h10, 8'h20, 8'hE0};
    flag = f;
    exec_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (seq.size() < 5) begin errors++; $display("FAIL flow_len flag=%b got %0d exp >=5", f, seq.size()); end
    else begin
      checks++;
      if ({seq[0], seq[1], seq[2], seq[3], seq[4]} !== {e0, e1, e2, e3, e4}) begin
        errors++; $display("FAIL flow_seq flag=%b got %0d %0d %0d %0d %0d exp %0d %0d %0d %0d %0d",
          f, seq[0], seq[1], seq[2], seq[3], seq[4], e0, e1, e2, e3, e4);
      end
    end
    if (f) begin
      checks++;
      if (acc.size() == 0 || acc[0] !== 8'h20 || acc[acc.size()-1] !== 8'h20) begin
        errors++; $display("FAIL flow_skip got n=%0d first=%h exp only 20", acc.size(), acc.size() ? acc[0] : 8'hxx);
      end
    end
    do_reset();
    flag = 1'b0;
  endtask

  task automatic test_step();
    int n = 0;
    rom = '{8'h13, 8'h25, 8'h30, 8'hF0};
    step_mode = 1'b1;
    exec_ready = 1'b1;
    pulse_start();
    while (pc != 2'd1 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, pc, exec_valid} !== {1'b1, 2'd1, 1'b0}) begin
        errors++; $display("FAIL step_wait cyc %0d got %b exp 1010", i, {busy, pc, exec_valid});
      end
    end
    pulse_start();
    checks++;
    if (pc !== 2'd1 || acc.size() !== 1) begin errors++; $display("FAIL step_start_busy got pc=%0d n=%0d exp pc=1 n=1", pc, acc.size()); end
    exec_ready = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    n = 0;
    while (!exec_valid && n < 20) begin tick(); n++; end
    step = 1'b1; tick(); step = 1'b0;
    exec_ready = 1'b1;
    tick();
    checks++;
    if (pc !== 2'd2 || acc.size() !== 2) begin errors++; $display("FAIL step_one got pc=%0d n=%0d exp pc=2 n=2", pc, acc.size()); end
    else begin
      checks++;
      if (acc[1] !== 8'h25) begin errors++; $display("FAIL step_op got %h exp 25", acc[1]); end
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pc !== 2'd2 || busy !== 1'b1 || acc.size() !== 2) begin
      errors++; $display("FAIL step_not_remembered got pc=%0d busy=%b n=%0d exp pc=2 busy=1 n=2", pc, busy, acc.size());
    end
    step = 1'b1; tick(); step = 1'b0;
    n = 0;
    while (pc != 2'd3 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (pc !== 2'd3 || acc.size() !== 3 || halted !== 1'b0) begin
      errors++; $display("FAIL step_two got pc=%0d n=%0d h=%b exp pc=3 n=3 h=0", pc, acc.size(), halted);
    end
    step = 1'b1; tick(); step = 1'b0;
    n = 0;
    while (!halted && n < 20) begin tick(); n++; end
    checks++;
    if (halted !== 1'b1 || pc !== 2'd3) begin errors++; $display("FAIL step_halt got h=%b pc=%0d exp h=1 pc=3", halted, pc); end
    step_mode = 1'b0;
  endtask

  task automatic test_wrap_restart();
    int n = 0;
    do_reset();
    rom = '{8'h10, 8'h10, 8'h10, 8'h10};
    exec_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (seq.size() < 5 || {seq[0], seq[1], seq[2], seq[3], seq[4]} !== {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}) begin
      errors++; $display("FAIL wrap_seq got n=%0d exp 0 1 2 3 0", seq.size());
    end
    rom[1] = 8'hF0;
    while (!halted && n < 40) begin tick(); n++; end
    checks++;
    if (halted !== 1'b1 || pc !== 2'd1) begin errors++; $display("FAIL wrap_halt got h=%b pc=%0d exp h=1 pc=1", halted, pc); end
    pulse_start();
    checks++;
    if ({pc, busy, halted} !== {2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL restart got %b exp 0010", {pc, busy, halted}); end
    do_reset();
  endtask

  task automatic test_fetch_wait3();
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (pc3 !== 2'((k / 5) % 4) || rom_addr3 !== pc3 || exec_valid3 !== (k % 5 == 4)) begin
        errors++; $display("FAIL fw3 k=%0d got pc=%0d addr=%0d v=%b exp pc=%0d v=%b",
          k, pc3, rom_addr3, exec_valid3, (k / 5) % 4, k % 5 == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_backpressure();
    test_reset_mid_issue();
    test_flow(1'b1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2);
    test_flow(1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0);
    test_step();
    test_wrap_restart();
    test_fetch_wait3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
